ef_tmr32_capture: RTL and testbench

//  Input-capture stage beside the 32-bit timer: consumes the live count tmr[31:0] and one raw pin.

---
 rtl/ef_tmr32_pkg.sv | 21 ++
 rtl/ef_tmr32_capture_if.sv | 34 +++
 rtl/ef_tmr32_cap_fifo.sv | 97 +++++++++
 rtl/ef_tmr32_capture.sv | 124 ++++++++++++
 tb/tb_ef_tmr32_capture.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/ef_tmr32_pkg.sv
// Shared definitions for the 32-bit timer block: capture edge/mode encodings and capture FSM states.
package ef_tmr32_pkg;

    localparam int unsigned TMR_W = 32;

    // cap_edge encodings: bit 0 selects rising edges, bit 1 selects falling edges
    localparam logic [1:0] CAP_EDGE_RISE = 2'b01;
    localparam logic [1:0] CAP_EDGE_FALL = 2'b10;
    localparam logic [1:0] CAP_EDGE_BOTH = 2'b11;

    // cap_mode encodings
    localparam logic CAP_MODE_TS    = 1'b0;
    localparam logic CAP_MODE_DELTA = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } cap_state_e;

endpackage

// File: rtl/ef_tmr32_capture_if.sv
// Register/bus side of the input-capture stage.
//   master (register layer): drives cap_en, cap_edge, cap_mode, rd, flush, ovf_clr;
//                            reads cap_data, cap_empty, cap_full, cap_level, cap_ovf, cap_evt.
//   slave  (capture stage):  the mirror image.
interface ef_tmr32_capture_if
    import ef_tmr32_pkg::*;
#(
    parameter int unsigned AW = 4
) ();

    logic             cap_en;
    logic [1:0]       cap_edge;
    logic             cap_mode;
    logic             rd;
    logic             flush;
    logic             ovf_clr;
    logic [TMR_W-1:0] cap_data;
    logic             cap_empty;
    logic             cap_full;
    logic [AW:0]      cap_level;
    logic             cap_ovf;
    logic             cap_evt;

    modport master (
        output cap_en, cap_edge, cap_mode, rd, flush, ovf_clr,
        input  cap_data, cap_empty, cap_full, cap_level, cap_ovf, cap_evt
    );

    modport slave (
        input  cap_en, cap_edge, cap_mode, rd, flush, ovf_clr,
        output cap_data, cap_empty, cap_full, cap_level, cap_ovf, cap_evt
    );

endinterface

// File: rtl/ef_tmr32_cap_fifo.sv
// Capture FIFO, 2**AW entries of DW bits. Full/empty derive from the level count.
//   push/wdata  : write request; dropped when full unless a pop is taken in the same cycle
//   pop         : remove head; ignored when empty
//   flush       : empty the FIFO; overrides push and pop
//   rdata       : head entry, valid when !empty
//   level       : entries held, 0..2**AW
//   accepted_c  : this cycle's push will be written
//   drop_c      : this cycle's push is being discarded because the FIFO is full
module ef_tmr32_cap_fifo
    import ef_tmr32_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    input  logic          flush,
    output logic [DW-1:0] rdata,
    output logic [AW:0]   level,
    output logic          empty,
    output logic          full,
    output logic          accepted_c,
    output logic          drop_c
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned LW    = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          pop_ok, wr_ok;

    // Pointer, level and storage update; a pop frees the slot a same-cycle push into a full FIFO needs
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        pop_ok     = pop & ~empty_q;
        wr_ok      = push & (~full_q | pop_ok);
        accepted_c = wr_ok & ~flush;
        drop_c     = push & full_q & ~pop & ~flush;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_ok) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            level_d = level_q + LW'(wr_ok) - LW'(pop_ok);
        end

        empty_d = (level_d == '0);
        full_d  = (level_d == LW'(DEPTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign level = level_q;
    assign empty = empty_q;
    assign full  = full_q;

endmodule

// File: rtl/ef_tmr32_capture.sv
// Input-capture stage beside the 32-bit timer. Synchronises a raw pin, detects the selected
// edge(s) and queues either the absolute timer value or the delta from the previous event.
//   clk, rst : clock, asynchronous active-high reset
//   tmr      : live timer count
//   cap_in   : raw asynchronous capture pin
//   bus      : register/bus side (enable/edge/mode config, pop/flush/ovf_clr, FIFO status, flags)
module ef_tmr32_capture
    import ef_tmr32_pkg::*;
#(
    parameter int unsigned AW       = 4,
    parameter int unsigned SYNC_STG = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [TMR_W-1:0] tmr,
    input  logic             cap_in,
    ef_tmr32_capture_if.slave bus
);

    logic [SYNC_STG-1:0] sync_q, sync_d;
    logic                s_d_q, s_d_d;
    logic                rise_c, fall_c, evt_c;
    cap_state_e          state_q, state_d;
    logic [TMR_W-1:0]    last_ts_q, last_ts_d;
    logic                push_c;
    logic [TMR_W-1:0]    push_data_c;
    logic                ovf_q, ovf_d;
    logic                evt_q, evt_d;
    logic                accepted_c, drop_c;

    // Pin synchroniser and edge detection; the history flop runs even while disabled
    always_comb begin
        sync_d = {sync_q[SYNC_STG-2:0], cap_in};
        s_d_d  = sync_q[SYNC_STG-1];
        rise_c = sync_q[SYNC_STG-1] & ~s_d_q;
        fall_c = ~sync_q[SYNC_STG-1] & s_d_q;
        evt_c  = bus.cap_en & ((rise_c & |(bus.cap_edge & CAP_EDGE_RISE)) |
                               (fall_c & |(bus.cap_edge & CAP_EDGE_FALL)));
    end

    // Capture FSM: ARMED swallows the first event in delta mode to seed last_ts
    always_comb begin
        state_d     = state_q;
        last_ts_d   = last_ts_q;
        push_c      = 1'b0;
        push_data_c = (bus.cap_mode == CAP_MODE_DELTA) ? (tmr - last_ts_q) : tmr;

        if (!bus.cap_en) begin
            state_d = ST_IDLE;
        end else if (bus.flush) begin
            state_d = (bus.cap_mode == CAP_MODE_DELTA) ? ST_ARMED : ST_RUN;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = (bus.cap_mode == CAP_MODE_DELTA) ? ST_ARMED : ST_RUN;
                end
                ST_ARMED: begin
                    if (evt_c) begin
                        last_ts_d = tmr;
                        state_d   = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (evt_c) begin
                        push_c    = 1'b1;
                        last_ts_d = tmr;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Sticky overflow: a drop in the same cycle as ovf_clr keeps it set
    always_comb begin
        ovf_d = ovf_q;
        if (drop_c) begin
            ovf_d = 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end
        evt_d = accepted_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            s_d_q     <= 1'b0;
            state_q   <= ST_IDLE;
            last_ts_q <= '0;
            ovf_q     <= 1'b0;
            evt_q     <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            s_d_q     <= s_d_d;
            state_q   <= state_d;
            last_ts_q <= last_ts_d;
            ovf_q     <= ovf_d;
            evt_q     <= evt_d;
        end
    end

    ef_tmr32_cap_fifo #(
        .DW (TMR_W),
        .AW (AW)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push_c),
        .wdata      (push_data_c),
        .pop        (bus.rd),
        .flush      (bus.flush),
        .rdata      (bus.cap_data),
        .level      (bus.cap_level),
        .empty      (bus.cap_empty),
        .full       (bus.cap_full),
        .accepted_c (accepted_c),
        .drop_c     (drop_c)
    );

    assign bus.cap_ovf = ovf_q;
    assign bus.cap_evt = evt_q;

endmodule

// File: tb/tb_ef_tmr32_capture.sv
// Directed bench for ef_tmr32_capture with a 4-entry FIFO (AW=2) and a 2-stage synchroniser.
module tb_ef_tmr32_capture;
    import ef_tmr32_pkg::*;

    localparam int unsigned AW = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] tmr;
    logic        cap_in;

    int n_checks = 0;
    int n_fail   = 0;

    ef_tmr32_capture_if #(.AW(AW)) bus ();

    ef_tmr32_capture #(
        .AW       (AW),
        .SYNC_STG (2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .tmr    (tmr),
        .cap_in (cap_in),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock, leaving time 1 after the rising edge for sampling/driving
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Toggle the pin with tmr held long enough for the event to be captured
    task automatic ev(input logic [31:0] t);
        tmr    = t;
        cap_in = ~cap_in;
        repeat (4) tick();
    endtask

    task automatic pop();
        bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0;
    endtask

    logic [31:0] drain_exp [4];

    initial begin
        rst          = 1'b1;
        tmr          = '0;
        cap_in       = 1'b0;
        bus.cap_en   = 1'b0;
        bus.cap_edge = 2'b00;
        bus.cap_mode = CAP_MODE_TS;
        bus.rd       = 1'b0;
        bus.flush    = 1'b0;
        bus.ovf_clr  = 1'b0;

        // Reset values
        repeat (2) tick();
        check_eq("rst_empty", 32'(bus.cap_empty), 32'd1);
        check_eq("rst_full",  32'(bus.cap_full),  32'd0);
        check_eq("rst_level", 32'(bus.cap_level), 32'd0);
        check_eq("rst_ovf",   32'(bus.cap_ovf),   32'd0);
        check_eq("rst_evt",   32'(bus.cap_evt),   32'd0);
        check_eq("rst_data",  bus.cap_data,       32'd0);
        rst = 1'b0;
        tick();

        // T1: timestamp mode, rising edge, ramping timer
        bus.cap_en   = 1'b1;
        bus.cap_edge = CAP_EDGE_RISE;
        bus.cap_mode = CAP_MODE_TS;
        repeat (3) tick();
        tmr    = 32'd1000;
        cap_in = 1'b1;
        tick();
        tmr = 32'd1001;
        tick();
        tmr = 32'd1002;             // evt is high in this cycle
        check_eq("t1_evt_pre",   32'(bus.cap_evt),   32'd0);
        check_eq("t1_level_pre", 32'(bus.cap_level), 32'd0);
        tick();
        check_eq("t1_evt",   32'(bus.cap_evt),   32'd1);
        check_eq("t1_level", 32'(bus.cap_level), 32'd1);
        check_eq("t1_data",  bus.cap_data,       32'd1002);
        check_eq("t1_empty", 32'(bus.cap_empty), 32'd0);
        tmr = 32'd1003;
        tick();
        check_eq("t1_evt_post", 32'(bus.cap_evt), 32'd0);
        pop();
        check_eq("t1_pop_empty", 32'(bus.cap_empty), 32'd1);
        check_eq("t1_pop_level", 32'(bus.cap_level), 32'd0);
        cap_in = 1'b0;              // falling edge is not selected
        repeat (4) tick();
        check_eq("t1_fall_ignored", 32'(bus.cap_level), 32'd0);

        // T2: delta mode, both edges; first event only arms
        bus.cap_mode = CAP_MODE_DELTA;
        bus.cap_edge = CAP_EDGE_BOTH;
        bus.flush    = 1'b1;
        tick();
        bus.flush = 1'b0;
        ev(32'd100);
        check_eq("t2_armed_nopush", 32'(bus.cap_level), 32'd0);
        ev(32'd350);
        ev(32'd600);
        check_eq("t2_level", 32'(bus.cap_level), 32'd2);
        check_eq("t2_data0", bus.cap_data,       32'd250);
        pop();
        check_eq("t2_data1", bus.cap_data,       32'd250);
        check_eq("t2_level1", 32'(bus.cap_level), 32'd1);
        pop();
        check_eq("t2_empty", 32'(bus.cap_empty), 32'd1);

        // T3: overfill a 4-entry FIFO
        bus.cap_mode = CAP_MODE_TS;
        bus.flush    = 1'b1;
        tick();
        bus.flush = 1'b0;
        ev(32'd10);
        ev(32'd20);
        ev(32'd30);
        ev(32'd40);
        check_eq("t3_ovf_before", 32'(bus.cap_ovf), 32'd0);
        ev(32'd50);
        check_eq("t3_level", 32'(bus.cap_level), 32'd4);
        check_eq("t3_full",  32'(bus.cap_full),  32'd1);
        check_eq("t3_ovf",   32'(bus.cap_ovf),   32'd1);
        check_eq("t3_head",  bus.cap_data,       32'd10);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        check_eq("t3_ovf_clr",   32'(bus.cap_ovf),   32'd0);
        check_eq("t3_level_clr", 32'(bus.cap_level), 32'd4);

        // T4: full FIFO, pop in the same cycle as the event
        tmr    = 32'd60;
        cap_in = ~cap_in;
        tick();
        tick();
        bus.rd = 1'b1;              // evt cycle
        tick();
        bus.rd = 1'b0;
        check_eq("t4_evt",   32'(bus.cap_evt),   32'd1);
        check_eq("t4_level", 32'(bus.cap_level), 32'd4);
        check_eq("t4_full",  32'(bus.cap_full),  32'd1);
        check_eq("t4_ovf",   32'(bus.cap_ovf),   32'd0);
        drain_exp = '{32'd20, 32'd30, 32'd40, 32'd60};
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("t4_drain%0d", i), bus.cap_data, drain_exp[i]);
            pop();
        end
        check_eq("t4_drained", 32'(bus.cap_empty), 32'd1);

        // T5: delta across timer wrap
        bus.cap_mode = CAP_MODE_DELTA;
        bus.flush    = 1'b1;
        tick();
        bus.flush = 1'b0;
        ev(32'hFFFF_FFFE);
        ev(32'h0000_0005);
        check_eq("t5_level", 32'(bus.cap_level), 32'd1);
        check_eq("t5_data",  bus.cap_data,       32'h0000_0007);

        // T6: mode switch without re-arm, then reset with an edge in flight
        bus.cap_mode = CAP_MODE_TS;
        ev(32'h0000_0111);
        ev(32'h0000_0222);
        check_eq("t6_level", 32'(bus.cap_level), 32'd3);
        check_eq("t6_head",  bus.cap_data,       32'h0000_0007);
        cap_in = ~cap_in;           // falls back to 0, so nothing remains after reset
        tick();
        rst = 1'b1;
        tick();
        tick();
        check_eq("t6_rst_level", 32'(bus.cap_level), 32'd0);
        check_eq("t6_rst_empty", 32'(bus.cap_empty), 32'd1);
        check_eq("t6_rst_full",  32'(bus.cap_full),  32'd0);
        check_eq("t6_rst_ovf",   32'(bus.cap_ovf),   32'd0);
        check_eq("t6_rst_evt",   32'(bus.cap_evt),   32'd0);
        check_eq("t6_rst_data",  bus.cap_data,       32'd0);
        rst = 1'b0;
        repeat (6) tick();
        check_eq("t6_post_level", 32'(bus.cap_level), 32'd0);
        check_eq("t6_post_empty", 32'(bus.cap_empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
